// File: rtl/commit_trace_checker.sv
// Lock-step retire checker: buffers expected commit records and compares each DUT retire against the head.
// Optional stall watchdog enabled by defining COMMIT_CHK_STALL_TIMEOUT_EN (adds parameter TIMEOUT, error code 6).
module commit_trace_checker #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int DEPTH     = 8,
  parameter int END_COUNT = 200,
  parameter int CW        = 16
`ifdef COMMIT_CHK_STALL_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          halt_i,
  input  logic          exp_valid_i,
  output logic          exp_ready_o,
  input  logic [AW-1:0] exp_pc_i,
  input  logic          exp_we_i,
  input  logic [4:0]    exp_rd_i,
  input  logic [DW-1:0] exp_data_i,
  input  logic          dut_valid_i,
  input  logic [AW-1:0] dut_pc_i,
  input  logic          dut_we_i,
  input  logic [4:0]    dut_rd_i,
  input  logic [DW-1:0] dut_data_i,
  output logic          busy_o,
  output logic          pass_o,
  output logic          fail_o,
  output logic [2:0]    err_code_o,
  output logic [CW-1:0] err_idx_o,
  output logic [CW-1:0] commit_cnt_o
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_UNDERRUN = 3'd4;
  localparam logic [2:0] E_LEFTOVER = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t        state_q, state_d;
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [2:0]    code_q, code_d;

  logic [AW-1:0] mem_pc   [DEPTH];
  logic          mem_we   [DEPTH];
  logic [4:0]    mem_rd   [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];

  logic [PW:0]   fill;
  logic          full;
  logic          empty;
  logic          running;
  logic          push;
  logic          exp_we_eff;
  logic          dut_we_eff;
  logic [AW-1:0] head_pc;
  logic          head_we;
  logic [4:0]    head_rd;
  logic [DW-1:0] head_data;
  logic [2:0]    cmp_code;
  logic [CW-1:0] cnt_inc;

`ifdef COMMIT_CHK_STALL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] E_TIMEOUT = 3'd6;
  logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
  assign tmr_inc = tmr_q + TW'(1);
`endif

  assign fill    = wr_ptr_q - rd_ptr_q;
  assign full    = (fill == (PW+1)'(DEPTH));
  assign empty   = (fill == '0);
  assign running = (state_q == S_RUN);
  // A full FIFO refuses pushes even when the head is popped in the same cycle.
  assign push    = running && exp_valid_i && !full;
  assign cnt_inc = cnt_q + CW'(1);

  // Writes to r0 are architecturally void, so fold rd==0 into the enable.
  assign exp_we_eff = exp_we_i && (exp_rd_i != 5'd0);
  assign dut_we_eff = dut_we_i && (dut_rd_i != 5'd0);

  assign head_pc   = mem_pc[rd_ptr_q[PW-1:0]];
  assign head_we   = mem_we[rd_ptr_q[PW-1:0]];
  assign head_rd   = mem_rd[rd_ptr_q[PW-1:0]];
  assign head_data = mem_data[rd_ptr_q[PW-1:0]];

  always_comb begin
    cmp_code = E_NONE;
    if (head_pc != dut_pc_i)
      cmp_code = 3'd1;
    else if ((head_we != dut_we_eff) || (head_we && (head_rd != dut_rd_i)))
      cmp_code = 3'd2;
    else if (head_we && (head_data != dut_data_i))
      cmp_code = 3'd3;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_pc[wr_ptr_q[PW-1:0]]   <= exp_pc_i;
      mem_we[wr_ptr_q[PW-1:0]]   <= exp_we_eff;
      mem_rd[wr_ptr_q[PW-1:0]]   <= exp_rd_i;
      mem_data[wr_ptr_q[PW-1:0]] <= exp_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      code_q   <= E_NONE;
`ifdef COMMIT_CHK_STALL_TIMEOUT_EN
      tmr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
`ifdef COMMIT_CHK_STALL_TIMEOUT_EN
      tmr_q    <= tmr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    code_d   = code_q;
`ifdef COMMIT_CHK_STALL_TIMEOUT_EN
    tmr_d    = tmr_q;
`endif
    unique case (state_q)
      S_RUN: begin
        if (push)
          wr_ptr_d = wr_ptr_q + (PW+1)'(1);
`ifdef COMMIT_CHK_STALL_TIMEOUT_EN
        tmr_d = dut_valid_i ? '0 : tmr_inc;
`endif
        // A commit outranks halt; a halt seen together with a commit is re-evaluated next cycle.
        if (dut_valid_i) begin
          if (empty) begin
            state_d = S_FAIL;
            code_d  = E_UNDERRUN;
            idx_d   = cnt_q;
          end else begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
            if (cmp_code != E_NONE) begin
              state_d = S_FAIL;
              code_d  = cmp_code;
              idx_d   = cnt_q;
            end else begin
              cnt_d = cnt_inc;
              if (cnt_inc == CW'(END_COUNT))
                state_d = S_PASS;
            end
          end
        end else if (halt_i) begin
          if (empty) begin
            state_d = S_PASS;
          end else begin
            state_d = S_FAIL;
            code_d  = E_LEFTOVER;
            idx_d   = cnt_q;
          end
        end
`ifdef COMMIT_CHK_STALL_TIMEOUT_EN
        else if (tmr_inc == TW'(TIMEOUT)) begin
          state_d = S_FAIL;
          code_d  = E_TIMEOUT;
          idx_d   = cnt_q;
        end
`endif
      end
      default: begin
        if (start_i) begin
          state_d  = S_RUN;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
          idx_d    = '0;
          code_d   = E_NONE;
`ifdef COMMIT_CHK_STALL_TIMEOUT_EN
          tmr_d    = '0;
`endif
        end
      end
    endcase
  end

  always_comb begin
    busy_o       = (state_q == S_RUN);
    pass_o       = (state_q == S_PASS);
    fail_o       = (state_q == S_FAIL);
    exp_ready_o  = running && !full;
    err_code_o   = code_q;
    err_idx_o    = idx_q;
    commit_cnt_o = cnt_q;
  end

endmodule

// File: doc/commit_trace_checker.md
Name: commit_trace_checker

Overview:
Synthesizable, parametrised lock-step checker for the Simple_Single_CPU family. It buffers expected retire records (pc, destination register, write data) from a golden model or trace ROM in an internal FIFO. Each DUT retire event is compared against the FIFO head, producing a registered PASS/FAIL verdict with error code and failing commit index. It replaces bench-only compare loops with a block that runs in simulation and on FPGA alongside the CPU.

Parameters:
AW, 32, PC width in bits
DW, 32, register write-data width in bits
DEPTH, 8, expected-record FIFO depth; power of 2, minimum 2
END_COUNT, 200, number of matched commits that ends the run with PASS
CW, 16, width of the commit and index counters

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
start_i  in  1  pulse; in IDLE/PASS/FAIL, clears FIFO and counters and enters RUN
halt_i  in  1  DUT reached end of program; sampled in RUN only
exp_valid_i  in  1  expected record valid
exp_ready_o  out  1  FIFO accepts a record this cycle
exp_pc_i  in  AW  expected pc of the retiring instruction
exp_we_i  in  1  expected register write enable
exp_rd_i  in  5  expected destination register
exp_data_i  in  DW  expected write data
dut_valid_i  in  1  DUT retired one instruction this cycle
dut_pc_i  in  AW  DUT pc
dut_we_i  in  1  DUT RegWrite
dut_rd_i  in  5  DUT write address
dut_data_i  in  DW  DUT write data
busy_o  out  1  state is RUN
pass_o  out  1  state is PASS
fail_o  out  1  state is FAIL
err_code_o  out  3  0 none, 1 pc, 2 we/rd, 3 data, 4 underflow, 5 leftover, 6 timeout
err_idx_o  out  CW  commit index of the failing record
commit_cnt_o  out  CW  matched commits since start

Behaviour:
- States: IDLE, RUN, PASS, FAIL. Reset: IDLE, FIFO empty, all outputs 0.
- IDLE/PASS/FAIL + start_i: next cycle RUN; FIFO pointers, commit_cnt_o, err_code_o and err_idx_o cleared. start_i in RUN is ignored.
- exp_ready_o = (state==RUN) && !full. Push on exp_valid_i && exp_ready_o. A full FIFO does not accept a push even when a pop occurs in the same cycle.
- Write normalisation on both sides: we_eff = we && (rd != 0). rd and data are compared only when we_eff = 1.
- RUN + dut_valid_i:
  - FIFO empty (including a push in the same cycle): FAIL, code 4. The head is never bypassed.
  - Otherwise pop the head and compare, with priority pc (1), then we_eff or rd (2), then data (3).
  - Mismatch: FAIL, err_idx_o = commit_cnt_o.
  - Match: commit_cnt_o increments. If the new value equals END_COUNT, go to PASS.
- The verdict is registered: state and err outputs update on the edge after the offending dut_valid_i cycle.
- RUN + halt_i without dut_valid_i: PASS if the FIFO is empty, else FAIL code 5. With dut_valid_i in the same cycle, the commit is evaluated first; halt_i takes effect next cycle if the state is still RUN.
- In PASS/FAIL: FIFO frozen, no push or pop, outputs held until start_i or reset.
- Reset asserted mid-RUN: next edge returns to IDLE with all state cleared, regardless of other inputs.
- Counters wrap modulo 2^CW; END_COUNT must be below 2^CW.

Optional Feature:
- Macro: COMMIT_CHK_STALL_TIMEOUT_EN.
- When defined:
  - Parameter TIMEOUT (default 64) exists.
  - A cycle counter runs in RUN; it clears on dut_valid_i and on entry to RUN.
  - When it reaches TIMEOUT: FAIL, code 6, err_idx_o = commit_cnt_o.
- When undefined: no counter and no TIMEOUT parameter; code 6 is never produced.

Test Plan:
- Reset, start, push 3 records (pc 0,4,8, we 1, rd 1,2,3), 3 matching DUT commits, halt_i -> pass_o=1, commit_cnt_o=3, err_code_o=0.
- Second DUT commit pc=12 vs expected 4 -> fail_o=1 one cycle later, err_code_o=1, err_idx_o=1.
- Expected rd=0 we=1 data=5, DUT we=0 -> match. Expected rd=8 data=0x10, DUT data=0x11 -> err_code_o=3.
- Fill FIFO to DEPTH=8 with exp_valid_i held high -> exp_ready_o=0 at 8 entries; commit with push pending -> push not taken that cycle, taken next cycle.
- dut_valid_i with empty FIFO and simultaneous push -> err_code_o=4. Separately, halt_i with 2 records left -> err_code_o=5.
- With END_COUNT=4, stream 5 matching records -> PASS after commit 4, fifth record left unchecked. Reset mid-run -> IDLE, counters 0. With macro defined and TIMEOUT=10, 10 idle cycles in RUN -> err_code_o=6.
